// File: rtl/lsu_pkg.sv
// Shared types and helpers for the load/store unit: funct3 encodings, FSM states,
// latched request fields, and the lane/alignment rules used at request accept.
package lsu_pkg;
  localparam logic [2:0] F3_B  = 3'd0;
  localparam logic [2:0] F3_H  = 3'd1;
  localparam logic [2:0] F3_W  = 3'd2;
  localparam logic [2:0] F3_BU = 3'd4;
  localparam logic [2:0] F3_HU = 3'd5;

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP} lsu_state_t;

  typedef struct packed {
    logic       store;
    logic [2:0] funct3;
    logic [1:0] addr_lo;
    logic [4:0] rd;
  } lsu_req_t;

  function automatic logic [3:0] store_mask(input logic [2:0] f3, input logic [1:0] a);
    case (f3)
      F3_B:    return 4'b0001 << a;
      F3_H:    return a[1] ? 4'b1100 : 4'b0011;
      F3_W:    return 4'b1111;
      default: return 4'b0000;
    endcase
  endfunction

  function automatic logic [31:0] store_data(input logic [2:0] f3, input logic [31:0] wd);
    case (f3)
      F3_B:    return {4{wd[7:0]}};
      F3_H:    return {2{wd[15:0]}};
      default: return wd;
    endcase
  endfunction

  function automatic logic misaligned(input logic [2:0] f3, input logic [1:0] a);
    case (f3)
      F3_H, F3_HU: return a[0];
      F3_W:        return a != 2'b00;
      default:     return 1'b0;
    endcase
  endfunction

  function automatic logic illegal_op(input logic store, input logic [2:0] f3);
    if (store) return f3 >= 3'd3;
    return (f3 == 3'd3) || (f3 == 3'd6) || (f3 == 3'd7);
  endfunction
endpackage

// File: rtl/lsu_load_format.sv
// Selects the addressed byte/halfword from a read word and extends it to 32 bits.
module lsu_load_format
  import lsu_pkg::*;
(
  input  logic [31:0] word,
  input  logic [2:0]  funct3,
  input  logic [1:0]  addr_lo,
  output logic [31:0] data
);
  logic [7:0]  b;
  logic [15:0] h;

  always_comb begin
    b = word[8*addr_lo +: 8];
    h = addr_lo[1] ? word[31:16] : word[15:0];
    case (funct3)
      F3_B:    data = {{24{b[7]}}, b};
      F3_BU:   data = {24'd0, b};
      F3_H:    data = {{16{h[15]}}, h};
      F3_HU:   data = {16'd0, h};
      default: data = word;
    endcase
  end
endmodule

// File: rtl/cpu_lsu.sv
// Load/store unit: one request at a time, drives a BRAM-style port with a fixed
// read latency and returns a register write-back response.
module cpu_lsu
  import lsu_pkg::*;
#(
  parameter int MEM_LATENCY = 1
) (
  input  logic        aclk,
  input  logic        aresetn,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_store,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [4:0]  req_rd,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic        resp_we,
  output logic [4:0]  resp_rd,
  output logic [31:0] resp_data,
  output logic        resp_err,
  output logic [31:0] addr_data,
  output logic [31:0] data_out_data,
  input  logic [31:0] data_in_data,
  output logic        en_data,
  output logic [3:0]  we_data
);
  localparam logic [2:0] LAT_LAST = 3'(MEM_LATENCY - 1);

  lsu_state_t  state;
  lsu_req_t    r;
  logic [2:0]  cnt;
  logic        req_err;
  logic [31:0] fmt;

  assign req_err = illegal_op(req_store, req_funct3) || misaligned(req_funct3, req_addr[1:0]);

  lsu_load_format u_fmt (
    .word    (data_in_data),
    .funct3  (r.funct3),
    .addr_lo (r.addr_lo),
    .data    (fmt)
  );

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      state         <= S_IDLE;
      cnt           <= '0;
      r             <= '0;
      req_ready     <= 1'b1;
      resp_valid    <= 1'b0;
      resp_we       <= 1'b0;
      resp_rd       <= '0;
      resp_data     <= '0;
      resp_err      <= 1'b0;
      addr_data     <= '0;
      data_out_data <= '0;
      en_data       <= 1'b0;
      we_data       <= '0;
    end else begin
      case (state)
        S_IDLE: if (req_valid) begin
          r         <= '{store: req_store, funct3: req_funct3, addr_lo: req_addr[1:0], rd: req_rd};
          req_ready <= 1'b0;
          addr_data <= {2'b00, req_addr[31:2]};
          if (req_err) begin
            // Rejected requests skip the memory entirely.
            state      <= S_RESP;
            resp_valid <= 1'b1;
            resp_err   <= 1'b1;
            resp_we    <= 1'b0;
            resp_data  <= '0;
            resp_rd    <= req_rd;
          end else begin
            state         <= S_ISSUE;
            en_data       <= 1'b1;
            we_data       <= req_store ? store_mask(req_funct3, req_addr[1:0]) : 4'b0000;
            data_out_data <= req_store ? store_data(req_funct3, req_wdata) : 32'd0;
          end
        end
        S_ISSUE: begin
          en_data <= 1'b0;
          we_data <= '0;
          if (r.store) begin
            state      <= S_RESP;
            resp_valid <= 1'b1;
            resp_err   <= 1'b0;
            resp_we    <= 1'b0;
            resp_data  <= '0;
            resp_rd    <= r.rd;
          end else begin
            state <= S_WAIT;
            cnt   <= '0;
          end
        end
        S_WAIT: if (cnt == LAT_LAST) begin
          cnt        <= '0;
          state      <= S_RESP;
          resp_valid <= 1'b1;
          resp_err   <= 1'b0;
          resp_we    <= (r.rd != 5'd0);
          resp_rd    <= r.rd;
          resp_data  <= fmt;
        end else begin
          cnt <= cnt + 3'd1;
        end
        S_RESP: if (resp_ready) begin
          state      <= S_IDLE;
          resp_valid <= 1'b0;
          req_ready  <= 1'b1;
        end
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_cpu_lsu.sv
// Directed bench for cpu_lsu: latency-1 instance for most vectors, latency-3 instance for timing.
module tb_cpu_lsu;
  logic        aclk = 1'b0;
  logic        aresetn = 1'b0;
  logic        req_valid = 1'b0, req_valid3 = 1'b0;
  logic        req_store = 1'b0;
  logic [2:0]  req_funct3 = '0;
  logic [31:0] req_addr = '0, req_wdata = '0, data_in_data = '0;
  logic [4:0]  req_rd = '0;
  logic        resp_ready = 1'b1, resp_ready3 = 1'b1;
  logic        req_ready, resp_valid, resp_we, resp_err, en_data;
  logic [4:0]  resp_rd;
  logic [31:0] resp_data, addr_data, data_out_data;
  logic [3:0]  we_data;
  logic        req_ready3, resp_valid3, resp_we3, resp_err3, en_data3;
  logic [4:0]  resp_rd3;
  logic [31:0] resp_data3, addr_data3, data_out_data3;
  logic [3:0]  we_data3;

  int tests = 0, fails = 0;
  logic en_seen = 1'b0, we_seen = 1'b0;

  always #5 aclk = ~aclk;

  cpu_lsu #(.MEM_LATENCY(1)) dut (
    .aclk(aclk), .aresetn(aresetn), .req_valid(req_valid), .req_ready(req_ready),
    .req_store(req_store), .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
    .req_rd(req_rd), .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_we(resp_we),
    .resp_rd(resp_rd), .resp_data(resp_data), .resp_err(resp_err), .addr_data(addr_data),
    .data_out_data(data_out_data), .data_in_data(data_in_data), .en_data(en_data), .we_data(we_data)
  );

  cpu_lsu #(.MEM_LATENCY(3)) dut3 (
    .aclk(aclk), .aresetn(aresetn), .req_valid(req_valid3), .req_ready(req_ready3),
    .req_store(req_store), .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
    .req_rd(req_rd), .resp_valid(resp_valid3), .resp_ready(resp_ready3), .resp_we(resp_we3),
    .resp_rd(resp_rd3), .resp_data(resp_data3), .resp_err(resp_err3), .addr_data(addr_data3),
    .data_out_data(data_out_data3), .data_in_data(data_in_data), .en_data(en_data3), .we_data(we_data3)
  );

  always @(negedge aclk) begin
    if (en_data) en_seen = 1'b1;
    if (we_data != 4'b0000) we_seen = 1'b1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    if (obs !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge aclk);
    #1;
  endtask

  // Presents one request in c0; returns in c1.
  task automatic issue(input logic st, input logic [2:0] f3, input logic [31:0] a,
                       input logic [31:0] wd, input logic [4:0] rd);
    req_store = st; req_funct3 = f3; req_addr = a; req_wdata = wd; req_rd = rd;
    req_valid = 1'b1;
    tick();
    req_valid = 1'b0;
  endtask

  // Cycle index (relative to accept c0) at which resp_valid is first seen.
  task automatic wait_resp(output int n);
    n = 1;
    while (!resp_valid && n < 20) begin
      tick();
      n++;
    end
  endtask

  task automatic do_load(input string tag, input logic [2:0] f3, input logic [31:0] a,
                         input logic [31:0] exp);
    int n;
    issue(1'b0, f3, a, 32'd0, 5'd1);
    wait_resp(n);
    chk({tag, "_lat"}, n, 3);
    chk({tag, "_data"}, resp_data, exp);
    chk({tag, "_err"}, {31'd0, resp_err}, 0);
    tick();
  endtask

  initial begin
    int n;
    repeat (2) tick();
    chk("rst_req_ready", {31'd0, req_ready}, 1);
    chk("rst_resp_valid", {31'd0, resp_valid}, 0);
    chk("rst_en", {31'd0, en_data}, 0);
    chk("rst_we", {28'd0, we_data}, 0);
    chk("rst_addr", addr_data, 0);
    aresetn = 1'b1;
    tick();

    issue(1'b1, 3'd2, 32'h10, 32'hDEADBEEF, 5'd0);
    chk("sw_en", {31'd0, en_data}, 1);
    chk("sw_we", {28'd0, we_data}, 4'b1111);
    chk("sw_addr", addr_data, 32'h4);
    chk("sw_dout", data_out_data, 32'hDEADBEEF);
    wait_resp(n);
    chk("sw_lat", n, 2);
    chk("sw_resp_we", {31'd0, resp_we}, 0);
    tick();

    data_in_data = 32'hDEADBEEF;
    issue(1'b0, 3'd2, 32'h10, 32'd0, 5'd5);
    chk("lw_en", {31'd0, en_data}, 1);
    chk("lw_we", {28'd0, we_data}, 0);
    wait_resp(n);
    chk("lw_lat", n, 3);
    chk("lw_data", resp_data, 32'hDEADBEEF);
    chk("lw_resp_we", {31'd0, resp_we}, 1);
    chk("lw_rd", {27'd0, resp_rd}, 5);
    tick();

    data_in_data = 32'h8081F07F;
    do_load("lb3",  3'd0, 32'h3, 32'hFFFFFF80);
    do_load("lbu3", 3'd4, 32'h3, 32'h00000080);
    do_load("lh2",  3'd1, 32'h2, 32'hFFFF8081);
    do_load("lhu0", 3'd5, 32'h0, 32'h0000F07F);
    do_load("lb0",  3'd0, 32'h0, 32'h0000007F);

    issue(1'b1, 3'd0, 32'h6, 32'h123456AB, 5'd0);
    chk("sb_we", {28'd0, we_data}, 4'b0100);
    chk("sb_dout", data_out_data, 32'hABABABAB);
    chk("sb_addr", addr_data, 32'h1);
    wait_resp(n);
    tick();
    issue(1'b1, 3'd1, 32'h2, 32'h0000BEEF, 5'd0);
    chk("sh_we", {28'd0, we_data}, 4'b1100);
    chk("sh_dout", data_out_data, 32'hBEEFBEEF);
    wait_resp(n);
    tick();

    en_seen = 1'b0;
    issue(1'b0, 3'd2, 32'h2, 32'd0, 5'd4);
    wait_resp(n);
    chk("elw_lat", n, 1);
    chk("elw_err", {31'd0, resp_err}, 1);
    chk("elw_we", {31'd0, resp_we}, 0);
    chk("elw_data", resp_data, 0);
    tick();
    chk("elw_no_en", {31'd0, en_seen}, 0);
    issue(1'b0, 3'd3, 32'h0, 32'd0, 5'd4);
    wait_resp(n);
    chk("ef3_err", {31'd0, resp_err}, 1);
    tick();
    we_seen = 1'b0; en_seen = 1'b0;
    issue(1'b1, 3'd1, 32'h1, 32'hFFFF, 5'd0);
    wait_resp(n);
    chk("esh_err", {31'd0, resp_err}, 1);
    tick();
    chk("esh_no_we", {31'd0, we_seen | en_seen}, 0);

    // Back-pressure with a competing request held on the port.
    data_in_data = 32'hDEADBEEF;
    resp_ready = 1'b0;
    issue(1'b0, 3'd2, 32'h10, 32'd0, 5'd7);
    wait_resp(n);
    chk("bp_lat", n, 3);
    req_store = 1'b0; req_funct3 = 3'd0; req_addr = 32'h0; req_rd = 5'd9; req_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("bp_hold", {resp_valid, resp_we, resp_err, req_ready, en_data, resp_rd}, {5'b11000, 5'd7});
      chk("bp_data", resp_data, 32'hDEADBEEF);
    end
    resp_ready = 1'b1;
    tick();
    chk("bp_idle_ready", {30'd0, req_ready, resp_valid}, 2'b10);
    tick();
    req_valid = 1'b0;
    chk("bp_next_issue", {31'd0, en_data}, 1);
    wait_resp(n);
    chk("bp_next_lat", n, 3);
    chk("bp_next_data", resp_data, 32'hFFFFFFEF);
    chk("bp_next_rd", {27'd0, resp_rd}, 9);
    tick();

    issue(1'b0, 3'd2, 32'h10, 32'd0, 5'd0);
    wait_resp(n);
    chk("rd0_we", {31'd0, resp_we}, 0);
    tick();

    // Reset while the load is in WAIT.
    issue(1'b0, 3'd2, 32'h10, 32'd0, 5'd3);
    tick();
    aresetn = 1'b0;
    tick();
    chk("wrst_state", {29'd0, req_ready, resp_valid, en_data}, 3'b100);
    aresetn = 1'b1;
    begin
      logic seen = 1'b0;
      for (int i = 0; i < 5; i++) begin
        tick();
        if (resp_valid) seen = 1'b1;
      end
      chk("wrst_no_resp", {31'd0, seen}, 0);
    end

    req_store = 1'b0; req_funct3 = 3'd2; req_addr = 32'h10; req_rd = 5'd5;
    req_valid3 = 1'b1;
    tick();
    req_valid3 = 1'b0;
    n = 1;
    while (!resp_valid3 && n < 20) begin
      tick();
      n++;
    end
    chk("l3_lat", n, 5);
    chk("l3_data", resp_data3, 32'hDEADBEEF);
    chk("l3_we", {31'd0, resp_we3}, 1);
    tick();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end
endmodule
